keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad on the breadboard and encodes the pressed key into a 4-bit hex code.
- It is the input-side counterpart of the seven-segment decoder, so its key output can drive seven_segment directly in place of the on-board switches.
- It drives the columns, samples the rows, debounces both press and release, and issues a one-cycle valid pulse for each accepted key.
- It runs on the 48 MHz HSOSC clock.

Parameters:
- SCAN_DIV, 48000: int_osc cycles per scan tick (1 ms at 48 MHz). Minimum 4.
- DEBOUNCE_CNT, 20: consecutive stable ticks needed to accept a press or a release. Minimum 2.
- REPEAT_TICKS, 250: ticks between auto-repeat pulses. Used only when KEYPAD_REPEAT_EN is defined.

Ports:
- int_osc, input, 1: system clock, 48 MHz.
- reset, input, 1: synchronous, active-high reset.
- row, input, 4: keypad rows. Active-low with external pull-ups. Asynchronous to int_osc.
- col, output, 4: keypad columns. Active-low, exactly one bit low at all times.
- key, output, 4: hex code of the last accepted key.
- key_valid, output, 1: one-cycle pulse when a key is accepted.
- key_held, output, 1: high while an accepted key remains pressed.

Behaviour:
- Reset (synchronous, active-high): col=4'b1110, key=4'h0, key_valid=0, key_held=0, state=SCAN, all counters 0.
- Row synchronizer:
  - row passes through 2 flops (rs) before any use, giving 2 cycles of latency.
  - No logic reads the raw row.
- Tick generator:
  - Free-running divider counts 0..SCAN_DIV-1 and wraps.
  - tick=1 on the cycle where the divider equals SCAN_DIV-1.
  - All state decisions occur only on tick cycles.
- Column sequence:
  - Order is 1110 -> 1101 -> 1011 -> 0111 -> 1110 (col0 first).
  - The column advances only on a tick in SCAN, or on the exit from DEBOUNCE or RELEASE back to SCAN.
- Key map (row r, col c) -> code:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D (E = *, F = #)
- State machine:
  - SCAN:
    - On tick, if exactly one rs bit is low: latch r/c, set cnt=1, go to DEBOUNCE, column frozen.
    - If zero or 2+ rs bits are low: advance the column and stay in SCAN. Multi-row presses are ignored.
  - DEBOUNCE:
    - On tick, if rs is still exactly the latched row low: cnt++.
    - When cnt reaches DEBOUNCE_CNT: register key=map(r,c), key_valid=1 for the next cycle, key_held=1, go to HELD.
    - Any other rs pattern: cnt=0, go to SCAN, advance the column. No output change.
  - HELD:
    - Column stays frozen. key_held=1.
    - On tick with the latched row high: cnt++. With it low: cnt=0.
    - When cnt reaches DEBOUNCE_CNT: key_held=0, go to SCAN, advance the column.
    - Presses on other keys (other rows in the same column, or other columns) are ignored. There is no rollover.
- key holds its last accepted value indefinitely. It is not cleared on release.
- key_valid is never high for 2 consecutive cycles.
- Reset asserted mid-operation forces the reset values on the next edge. No pulse is emitted.
- Latency: press stable at the pins -> key_valid is at most (4+DEBOUNCE_CNT)*SCAN_DIV+3 cycles.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN (auto-repeat).
- Defined:
  - In HELD, a repeat counter counts ticks from entry into HELD.
  - Every REPEAT_TICKS ticks, key_valid pulses for one cycle with an unchanged key.
  - The repeat counter resets on leaving HELD.
  - A release-debounce tick does not suppress a repeat.
- Undefined: exactly one key_valid per press. The repeat counter logic is absent.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_TICKS=5; the bench models the keypad as row[r]=0 when col[c]=0 and (r,c) is pressed):
1. Reset, then idle for 40 cycles -> col cycles 1110,1101,1011,0111 every 4 cycles; key_valid=0; key=0; key_held=0.
2. Press (r2,c1) cleanly -> exactly one key_valid pulse with key=4'h8, then key_held=1 and col stays at 1101. Release -> key_held drops after 3 high ticks and scanning resumes.
3. Press (r0,c3) with bounce (toggles every 2 ticks for 4 ticks, then stable) -> no pulse during bounce, a single pulse with key=4'hA after stability, and no extra pulses on a bouncy release.
4. Press (r1,c0) and (r3,c0) simultaneously -> no key_valid, scanning continues. Release r3 -> pulse with key=4'h4.
5. Hold (r3,c1), then also press (r0,c2) -> single pulse key=4'h0, with (r0,c2) ignored. Release both -> (r0,c2) is not reported unless pressed again.
6. Assert reset during DEBOUNCE on (r0,c0) -> outputs return to reset values and no pulse. With KEYPAD_REPEAT_EN, hold (r0,c0) for 30 ticks -> pulses key=4'h1 at acceptance and every 5 ticks thereafter.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives active-low columns, debounces press and release,
// emits a one-cycle key_valid per accepted key. Optional auto-repeat under KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV     = 48000,
  parameter int DEBOUNCE_CNT = 20,
  parameter int REPEAT_TICKS = 250
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] state_dbg
);

  // Handshake: key_valid is a one-cycle strobe with no ready; key is stable whenever key_valid is high.

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CNT);

  state_t        state, state_n;
  logic [3:0]    rs_meta, rs;
  logic [DW-1:0] div;
  logic          tick;
  logic [1:0]    col_idx, col_idx_n;
  logic [1:0]    r_lat, r_lat_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    key_n;
  logic          valid_n, held_n;
  logic          one_low;
  logic [1:0]    row_idx;
  logic          lat_low;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_TICKS);
  logic [RW-1:0] rep_cnt, rep_n, rep_inc;
`endif

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign tick      = (div == DIV_LAST);
  assign col       = ~(4'b0001 << col_idx);
  assign state_dbg = state;
  assign cnt_inc   = cnt + 1'b1;
  assign lat_low   = (rs == ~(4'b0001 << r_lat));

  always_comb begin
    one_low = 1'b1;
    row_idx = 2'd0;
    case (rs)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      rs_meta   <= 4'hF;
      rs        <= 4'hF;
      div       <= '0;
      state     <= SCAN;
      col_idx   <= 2'd0;
      r_lat     <= 2'd0;
      cnt       <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      rs_meta   <= row;
      rs        <= rs_meta;
      div       <= tick ? '0 : div + 1'b1;
      state     <= state_n;
      col_idx   <= col_idx_n;
      r_lat     <= r_lat_n;
      cnt       <= cnt_n;
      key       <= key_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  assign rep_inc = rep_cnt + 1'b1;

  always_ff @(posedge int_osc) begin
    if (reset) rep_cnt <= '0;
    else       rep_cnt <= rep_n;
  end
`endif

  // Column stays frozen outside SCAN so the latched key keeps being observed on its row.
  always_comb begin
    state_n   = state;
    col_idx_n = col_idx;
    r_lat_n   = r_lat;
    cnt_n     = cnt;
    key_n     = key;
    valid_n   = 1'b0;
    held_n    = key_held;
`ifdef KEYPAD_REPEAT_EN
    rep_n     = rep_cnt;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (one_low) begin
            r_lat_n = row_idx;
            cnt_n   = CW'(1);
            state_n = DEBOUNCE;
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (lat_low) begin
            if (cnt_inc == DEB_MAX) begin
              key_n   = key_code(r_lat, col_idx);
              valid_n = 1'b1;
              held_n  = 1'b1;
              cnt_n   = '0;
              state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_n   = '0;
`endif
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n     = '0;
            state_n   = SCAN;
            col_idx_n = col_idx + 2'd1;
          end
        end
        HELD: begin
`ifdef KEYPAD_REPEAT_EN
          if (rep_inc == REP_MAX) begin
            valid_n = 1'b1;
            rep_n   = '0;
          end else begin
            rep_n = rep_inc;
          end
`endif
          if (rs[r_lat]) begin
            if (cnt_inc == DEB_MAX) begin
              held_n    = 1'b0;
              cnt_n     = '0;
              state_n   = SCAN;
              col_idx_n = col_idx + 2'd1;
`ifdef KEYPAD_REPEAT_EN
              rep_n     = '0;
`endif
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: begin
          state_n = SCAN;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule
